// File: rtl/leds_racer_core_multi.sv
// LEDs racer race core: per-button sync/debounce/edge detect, position counters,
// race FSM with winner latch, frame req/ack. Optional build macro: LEDS_RACER_TIE_DETECT_EN.
//
// state    | meaning
// S_IDLE   | waiting for the first accepted press
// S_RACE   | presses advance positions
// S_FINISH | winner latched, presses ignored until force_reset
module leds_racer_core_multi #(
  parameter int NUM_PLAYERS      = 4,
  parameter int MAX_POS          = 109,
  parameter int DEBOUNCE_CLK_CNT = 65536,
  localparam int POS_W = $clog2(MAX_POS + 1),
  localparam int ID_W  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         force_reset,
  input  logic [NUM_PLAYERS-1:0]       player_inputs,
  output logic [NUM_PLAYERS*POS_W-1:0] positions,
  output logic [1:0]                   race_state,
  output logic                         winner_valid,
  output logic [ID_W-1:0]              winner_id,
  output logic                         tie,
  output logic                         frame_req,
  input  logic                         frame_ack
);

  localparam int CNT_W = $clog2(DEBOUNCE_CLK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLK_CNT - 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0] POS_PRE  = POS_W'(MAX_POS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RACE   = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  state_t state_q, state_n;

  logic [NUM_PLAYERS-1:0] sync1_q, sync2_q, level_q, level_d_q, press_q;
  logic [CNT_W-1:0]       db_cnt_q [NUM_PLAYERS];

  logic [POS_W-1:0]       pos_q [NUM_PLAYERS];
  logic [POS_W-1:0]       pos_n [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] inc, reach;
  logic [ID_W-1:0]        win_id_q, win_id_n;
  logic                   win_valid_q;
  logic                   changed_now, changed_q, frame_req_q;

  // Input conditioning: level changes only after DEBOUNCE_CLK_CNT differing cycles
  always_ff @(posedge clk) begin
    if (force_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      level_d_q <= '0;
      press_q   <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= player_inputs;
      sync2_q   <= sync1_q;
      level_d_q <= level_q;
      press_q   <= level_q & ~level_d_q;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_LAST) begin
          level_q[i]  <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (force_reset) begin
      state_q     <= S_IDLE;
      win_id_q    <= '0;
      win_valid_q <= 1'b0;
      changed_q   <= 1'b0;
      frame_req_q <= 1'b1;
      for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= '0;
    end else begin
      state_q     <= state_n;
      win_id_q    <= win_id_n;
      win_valid_q <= (state_n == S_FINISH);
      changed_q   <= changed_now;
      // a change landing on an ack edge keeps the pending request alive
      frame_req_q <= changed_q | (frame_req_q & (~frame_ack | changed_now));
      for (int i = 0; i < NUM_PLAYERS; i++) pos_q[i] <= pos_n[i];
    end
  end

  always_comb begin
    state_n  = state_q;
    win_id_n = win_id_q;
    inc      = '0;
    reach    = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) pos_n[i] = pos_q[i];

    case (state_q)
      S_IDLE, S_RACE: begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (press_q[i] && (pos_q[i] != POS_MAX)) begin
            inc[i]   = 1'b1;
            pos_n[i] = pos_q[i] + POS_W'(1);
            if (pos_q[i] == POS_PRE) reach[i] = 1'b1;
          end
        end
        if (|reach) begin
          state_n = S_FINISH;
          for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (reach[i]) win_id_n = ID_W'(i);
          end
        end else if (|press_q) begin
          state_n = S_RACE;
        end
      end
      default: begin
        state_n = S_FINISH;
      end
    endcase

    changed_now = (|inc) || (state_n != state_q);
  end

`ifdef LEDS_RACER_TIE_DETECT_EN
  logic tie_q, tie_n;

  always_comb begin
    tie_n = tie_q;
    if (|reach) tie_n = ($countones(reach) > 1);
  end

  always_ff @(posedge clk) begin
    if (force_reset) tie_q <= 1'b0;
    else             tie_q <= tie_n;
  end

  assign tie = tie_q;
`else
  assign tie = 1'b0;
`endif

  always_comb begin
    positions = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) positions[i*POS_W +: POS_W] = pos_q[i];
  end

  assign race_state   = state_q;
  assign winner_valid = win_valid_q;
  assign winner_id    = win_id_q;
  assign frame_req    = frame_req_q;

endmodule

// File: doc/leds_racer_core_multi.md
# leds_racer_core_multi

Parametrised race-logic core for the LEDs racer. It takes NUM_PLAYERS raw push-button inputs, then synchronises, debounces and edge-detects each one. It advances one position counter per player on every press and runs the IDLE/RACE/FINISHED race state machine with winner latching. It sits between the board or TinyTapeout pin wrapper and the WS2812 frame/LED-line driver, and hands frames over with a req/ack handshake.

## Interface
- NUM_PLAYERS, 4, number of player channels, 1..8
- MAX_POS, 109, finish position (last LED index), ≥1
- DEBOUNCE_CLK_CNT, 65536, consecutive stable cycles required to accept a level change, ≥1
- Derived: POS_W = $clog2(MAX_POS+1), ID_W = max(1,$clog2(NUM_PLAYERS))

Ports:
- clk  in  1  single clock; all logic on rising edge
- force_reset  in  1  synchronous, active-high reset
- player_inputs  in  NUM_PLAYERS  raw asynchronous buttons, bit i = player i, active-high
- positions  out  NUM_PLAYERS*POS_W  packed; player i at [i*POS_W +: POS_W]
- race_state  out  2  00 IDLE, 01 RACE, 10 FINISHED
- winner_valid  out  1  high in FINISHED
- winner_id  out  ID_W  index of winning player
- tie  out  1  more than one player finished in the same cycle
- frame_req  out  1  new frame content pending for the LED driver
- frame_ack  in  1  driver has latched the current positions/state

## Operation
- Per channel: 2-flop synchroniser, then debounce counter of width $clog2(DEBOUNCE_CLK_CNT+1).
  - Counter resets to 0 whenever the synced value equals the debounced level.
  - When the synced value differs for DEBOUNCE_CLK_CNT consecutive cycles, the debounced level takes the new value and the counter clears.
  - A glitch shorter than DEBOUNCE_CLK_CNT cycles produces no change.
- press[i] is a one-cycle pulse on a debounced rising edge. Falling edges produce no action.
- IDLE:
  - Any press → RACE in the same update cycle.
  - That press counts: the pressing player's position goes +1.
- RACE:
  - Each press[i] increments position i.
  - Simultaneous presses all increment in the same cycle.
  - A player whose position reaches MAX_POS moves the FSM to FINISHED, sets winner_valid=1, and sets winner_id to the lowest index among the players reaching MAX_POS that cycle.
- FINISHED:
  - All presses are ignored.
  - Positions, winner_id and tie are frozen.
  - Only force_reset leaves this state.
- Positions saturate at MAX_POS and never wrap.
- frame_req:
  - Set in the cycle after any change to positions or race_state.
  - Cleared when frame_ack is sampled high.
  - A change in the same cycle as an ack keeps or re-asserts req (the new content is not lost).
  - Multiple changes while req is high merge into one request.
- force_reset mid-race: the FSM goes to IDLE, all state clears, and debounced levels are set to 0. A button held through reset produces a press after the debounce period once reset is released.

## Timing
- Reset values: positions=0, race_state=00, winner_valid=0, winner_id=0, tie=0, frame_req=1 (request a blanking frame). Debounce counters, synchronisers and debounced levels are all 0.
- Input latency: raw input stable high from edge 0 → press pulse registered at edge 2+DEBOUNCE_CLK_CNT → positions/race_state update at edge 3+DEBOUNCE_CLK_CNT → frame_req high at edge 4+DEBOUNCE_CLK_CNT.
- winner_valid, winner_id and tie update on the same edge as the finishing position.
- All outputs are registered; there is no combinational path from inputs to outputs.
- frame_ack is honoured only while frame_req=1; an ack with req=0 is ignored.

## Configuration
- LEDS_RACER_TIE_DETECT_EN defined:
  - tie=1 when two or more players reach MAX_POS in the same cycle.
  - winner_id is still the lowest such index.
- LEDS_RACER_TIE_DETECT_EN undefined:
  - The tie port is driven constant 0 and the tie logic is not built.
  - Lowest-index-wins is unchanged.

## Test plan
All scenarios use NUM_PLAYERS=4, MAX_POS=5 and DEBOUNCE_CLK_CNT=4 unless stated.
- Reset: force_reset held 3 cycles → all positions 0, race_state=00, frame_req=1. Pulse frame_ack 1 cycle → frame_req=0.
- Debounce: player 1 high for 3 cycles then low → no change. High for 6 cycles → position1=1 at edge 7, race_state=01, frame_req rises the next cycle.
- Race to finish: player 2 pressed 5 times → position2=5, race_state=10, winner_valid=1, winner_id=2. Further presses from any player leave all outputs unchanged.
- Simultaneous finish: players 0 and 3 both at 4, pressed in the same cycle → both reach 5, winner_id=0. tie=1 with LEDS_RACER_TIE_DETECT_EN, tie=0 without it.
- Handshake merge: hold frame_ack=0 and generate 3 presses → frame_req stays 1. A press landing in the same cycle as frame_ack → frame_req remains 1 on the next cycle.
- Mid-race reset: positions {2,1,0,3} in RACE, then force_reset for 1 cycle → all 0, state IDLE. A button held through reset gives position=1 exactly DEBOUNCE_CLK_CNT+3 cycles after release.
